// File: rtl/updown_count_arbiter.sv
// updown_count_arbiter: round-robin scheduler feeding bursts to a shared up/down count register
module updown_count_arbiter #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              dir_a,
    input  logic [STEP_W-1:0] steps_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic              dir_b,
    input  logic [STEP_W-1:0] steps_b,
    output logic              gnt_b,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              owner,
    output logic              done,
    output logic              wrap
);
    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;
    state_t state;
    logic dir_q;
    logic last_owner;
    logic [STEP_W-1:0] rem_q;
    logic pick_b;
    logic wrap_hit;
    logic [WIDTH-1:0] next_count;
    // on a tie the requester that was not served last wins
    always_comb begin
        pick_b     = req_b & (~req_a | ~last_owner);
        next_count = dir_q ? count + 1'b1 : count - 1'b1;
        wrap_hit   = dir_q ? &count : ~|count;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            owner      <= 1'b1;
            last_owner <= 1'b1;
            dir_q      <= 1'b0;
            rem_q      <= '0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
            case (state)
                IDLE: if (req_a | req_b) begin
                    state <= GRANT;
                    busy  <= 1'b1;
                    owner <= pick_b;
                    gnt_a <= ~pick_b;
                    gnt_b <= pick_b;
                    dir_q <= pick_b ? dir_b : dir_a;
                    rem_q <= pick_b ? steps_b : steps_a;
                end
                GRANT: begin
                    state <= (rem_q == '0) ? DONE : RUN;
                    busy  <= (rem_q != '0);
                    done  <= (rem_q == '0);
                end
                RUN: begin
                    count <= next_count;
                    wrap  <= wrap_hit;
                    rem_q <= rem_q - 1'b1;
                    state <= (rem_q == STEP_W'(1)) ? DONE : RUN;
                    busy  <= (rem_q != STEP_W'(1));
                    done  <= (rem_q == STEP_W'(1));
                end
                DONE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/updown_count_arbiter.md
Name: updown_count_arbiter

Overview:
Shared up/down count engine with a scheduler in front of it, serving two independent requesters A and B. Each requester asks for a burst of N steps in a chosen direction. A round-robin arbiter grants one request at a time. The controller then sequences the counter one step per clock until the burst completes. It sits between the control logic and the 4-bit up/down count register that drives the display/LED path.

Parameters:
WIDTH, 4, bit width of the shared count register (wraps modulo 2^WIDTH)
STEP_W, 4, bit width of the step-count field of each request

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req_a  input  1  requester A request, level; held until gnt_a
dir_a  input  1  requester A direction: 1 = up, 0 = down
steps_a  input  STEP_W  requester A number of steps
gnt_a  output  1  one-cycle grant pulse to A
req_b  input  1  requester B request, level
dir_b  input  1  requester B direction
steps_b  input  STEP_W  requester B number of steps
gnt_b  output  1  one-cycle grant pulse to B
count  output  WIDTH  shared count value
busy  output  1  high in GRANT and RUN
owner  output  1  current/last granted requester: 0 = A, 1 = B
done  output  1  one-cycle pulse when a burst finishes
wrap  output  1  one-cycle pulse on the cycle count wraps (max->0 or 0->max)

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, gnt_a=gnt_b=0, busy=0, done=0, wrap=0, owner=1, last_owner=B. As a result A wins the first tie.
- FSM states: IDLE, GRANT, RUN, DONE. All outputs are registered.
- IDLE: requests are sampled at each edge.
  - Only req_a high: grant A. Only req_b high: grant B.
  - Both high: grant the one that is not last_owner.
  - On grant: latch dir/steps of the winner into dir_q/rem_q, set owner, go to GRANT.
- GRANT (1 cycle): the winner's gnt is high for exactly this cycle and busy=1.
  - rem_q==0: go to DONE with no count change.
  - Otherwise go to RUN.
- RUN: at each edge, count <= count+1 (dir_q=1) or count-1 (dir_q=0), modulo 2^WIDTH, and rem_q <= rem_q-1.
  - wrap is high in the cycle after an edge where count went 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
  - The edge that decrements rem_q from 1 to 0 performs the last step and moves to DONE.
- DONE (1 cycle): done=1, busy=0, last_owner <= owner, next state IDLE.
- Latency:
  - req sampled at edge T -> gnt high during T..T+1.
  - First count change at edge T+2.
  - N-step burst: last change at edge T+1+N.
  - done high in the cycle following that edge.
  - Next grant decision is no earlier than the edge after done.
- Requests arriving while busy or in DONE are not granted, queued or dropped. Requesters keep req asserted until they see gnt.
- dir/steps inputs are only sampled at grant. Later changes do not affect the running burst.
- A requester that keeps req high after its grant is re-granted only if the other requester is idle (round-robin fairness).
- Reset asserted mid-RUN aborts the burst immediately: count=0 and no done pulse.
- steps = 2^STEP_W-1 (15) is legal. Up from 0 ends at 15 with no wrap. Up from 1 ends at 0 with one wrap pulse.
- gnt_a and gnt_b are never high in the same cycle. done and gnt are never high in the same cycle.

Test Plan:
- Reset then a single A burst up: rst low 50 ns then high; req_a=1, dir_a=1, steps_a=5 -> gnt_a one pulse; count 0->1->2->3->4->5 on 5 consecutive edges; done one pulse; owner=0; wrap never high.
- Down wrap: from count=0, req_b, dir_b=0, steps_b=3 -> count 15,14,13; wrap high exactly once, in the cycle after 0->15; done one pulse; owner=1.
- Simultaneous requests after reset: req_a=req_b=1, both steps=2 up -> A granted first (count 0->2). Then B is granted without deasserting (count 2->4). Exactly two gnt pulses, in order A then B.
- Fairness under saturation: req_a and req_b held high for 6 bursts of steps=1 -> grants alternate A,B,A,B,A,B; count ends at 6.
- Zero-step and mid-burst changes: steps_a=0 -> gnt_a, then done two cycles later with count unchanged. Next, grant B with steps=8 up and toggle dir_b during RUN -> count still increases by exactly 8.
- Reset mid-operation: rst low during RUN of a steps=10 burst at count=4 -> count=0, busy=0, no done. After release, req_a and req_b both high -> A granted first.
